// File: rtl/salsa_round_sched.sv
// Two-slot interleaved sequencer for a shared 2-stage salsa_core. Each slot recirculates
// its block DROUNDS double rounds, adds the feed-forward and returns it over valid/ready.
module salsa_round_sched #(
  parameter int DROUNDS = 4,
  parameter int IDW     = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [511:0]   in_data,
  input  logic [IDW-1:0] in_id,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [511:0]   out_data,
  output logic [IDW-1:0] out_id,
  output logic [511:0]   core_xx,
  input  logic [511:0]   core_out,
  output logic           core_issue
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [3:0] LP_LAST = 4'(DROUNDS);

  logic             r_phase;
  logic [1:0]       r_state     [2];
  logic [1:0]       w_state_nxt [2];
  logic [511:0]     r_orig      [2];
  logic [511:0]     r_res       [2];
  logic [IDW-1:0]   r_id        [2];
  logic [3:0]       r_cnt       [2];
  logic [1:0]       r_age;

  logic [1:0]       w_cur;
  logic [3:0]       w_n;
  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic [1:0]       w_done;
  logic             w_sel;
  logic             w_emit;
  logic [511:0]     w_ffadd;

  assign w_cur    = r_state[r_phase];
  assign w_n      = r_cnt[r_phase] + 4'd1;
  assign w_accept = (w_cur == S_IDLE) && in_valid;
  assign w_run    = (w_cur == S_RUN);
  assign w_last   = w_run && (w_n == LP_LAST);
  assign w_done   = {r_state[1] == S_DONE, r_state[0] == S_DONE};
  // with both slots done, the one whose done_age is set finished first
  assign w_sel    = (&w_done) ? r_age[1] : w_done[1];
  assign w_emit   = out_valid && out_ready;

  always_comb begin
    w_ffadd = '0;
    for (int w = 0; w < 16; w++) begin
      w_ffadd[32*w +: 32] = r_orig[r_phase][32*w +: 32] + core_out[32*w +: 32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase    <= 1'b0;
      r_state[0] <= S_IDLE;
      r_state[1] <= S_IDLE;
    end else begin
      r_phase    <= ~r_phase;
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
    end
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_state_nxt[s] = r_state[s];
      if (w_emit && (w_sel == 1'(s))) begin
        w_state_nxt[s] = S_IDLE;
      end else if (r_phase == 1'(s)) begin
        case (r_state[s])
          S_IDLE:  if (in_valid) w_state_nxt[s] = S_RUN;
          S_RUN:   if (w_n == LP_LAST) w_state_nxt[s] = S_DONE;
          S_DONE:  w_state_nxt[s] = S_DONE;
          default: w_state_nxt[s] = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        r_orig[s] <= '0;
        r_res[s]  <= '0;
        r_id[s]   <= '0;
        r_cnt[s]  <= '0;
      end
      r_age <= '0;
    end else if (w_accept) begin
      r_orig[r_phase] <= in_data;
      r_id[r_phase]   <= in_id;
      r_cnt[r_phase]  <= '0;
    end else if (w_last) begin
      r_res[r_phase]  <= w_ffadd;
      r_age[r_phase]  <= 1'b0;
      r_age[~r_phase] <= 1'b1;
    end else if (w_run) begin
      r_cnt[r_phase]  <= w_n;
    end
  end

  always_comb begin
    in_ready   = (w_cur == S_IDLE);
    core_xx    = '0;
    core_issue = 1'b0;
    // core is quiet while reset is held even if in_valid is asserted
    if (!reset) begin
      if (w_accept) begin
        core_xx    = in_data;
        core_issue = 1'b1;
      end else if (w_run && !w_last) begin
        core_xx    = core_out;
        core_issue = 1'b1;
      end
    end
    out_valid = |w_done;
    out_data  = r_res[w_sel];
    out_id    = r_id[w_sel];
  end

endmodule

// File: tb/tb_salsa_round_sched.sv
// Scoreboard bench for salsa_round_sched with a behavioural 2-stage Salsa double-round core.
module tb_salsa_round_sched;
  localparam int DR  = 4;
  localparam int IDW = 4;

  logic           clk;
  logic           reset;
  logic           in_valid, in_ready, out_valid, out_ready, core_issue;
  logic [511:0]   in_data, out_data, core_xx, core_out;
  logic [IDW-1:0] in_id, out_id;

  logic           in_valid1, in_ready1, out_valid1, out_ready1, core_issue1;
  logic [511:0]   in_data1, out_data1, core_xx1, core_out1;
  logic [IDW-1:0] in_id1, out_id1;

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_pop = 0;

  typedef struct { logic [IDW-1:0] id; logic [511:0] data; } exp_t;
  exp_t exp_q[$];

  salsa_round_sched #(.DROUNDS(DR), .IDW(IDW)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_id(in_id), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .core_xx(core_xx), .core_out(core_out), .core_issue(core_issue));

  salsa_round_sched #(.DROUNDS(1), .IDW(IDW)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .in_id(in_id1), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_id(out_id1), .core_xx(core_xx1), .core_out(core_out1), .core_issue(core_issue1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    logic [31:0] ta, tb, tc, td;
    ta = a; tb = b; tc = c; td = d;
    tb = tb ^ rotl(ta + td, 7);
    tc = tc ^ rotl(tb + ta, 9);
    td = td ^ rotl(tc + tb, 13);
    ta = ta ^ rotl(td + tc, 18);
    return {ta, tb, tc, td};
  endfunction

  function automatic logic [511:0] dround(input logic [511:0] blk);
    logic [31:0]  x[16];
    logic [511:0] r;
    for (int i = 0; i < 16; i++) x[i] = blk[32*i +: 32];
    {x[0],  x[4],  x[8],  x[12]} = qr(x[0],  x[4],  x[8],  x[12]);
    {x[5],  x[9],  x[13], x[1]}  = qr(x[5],  x[9],  x[13], x[1]);
    {x[10], x[14], x[2],  x[6]}  = qr(x[10], x[14], x[2],  x[6]);
    {x[15], x[3],  x[7],  x[11]} = qr(x[15], x[3],  x[7],  x[11]);
    {x[0],  x[1],  x[2],  x[3]}  = qr(x[0],  x[1],  x[2],  x[3]);
    {x[5],  x[6],  x[7],  x[4]}  = qr(x[5],  x[6],  x[7],  x[4]);
    {x[10], x[11], x[8],  x[9]}  = qr(x[10], x[11], x[8],  x[9]);
    {x[15], x[12], x[13], x[14]} = qr(x[15], x[12], x[13], x[14]);
    r = '0;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i];
    return r;
  endfunction

  function automatic logic [511:0] salsa_ref(input logic [511:0] blk, input int nd);
    logic [511:0] x, r;
    x = blk;
    for (int i = 0; i < nd; i++) x = dround(x);
    r = '0;
    for (int w = 0; w < 16; w++) r[32*w +: 32] = blk[32*w +: 32] + x[32*w +: 32];
    return r;
  endfunction

  function automatic logic [511:0] bytes_to_blk(input logic [511:0] s);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 64; k++) r[8*k +: 8] = s[511 - 8*k -: 8];
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // behavioural salsa_core: one double round, two register stages
  logic [511:0] c0_p1, c0_p2, c1_p1, c1_p2;
  always @(posedge clk) begin
    c0_p1 <= dround(core_xx);
    c0_p2 <= c0_p1;
    c1_p1 <= dround(core_xx1);
    c1_p2 <= c1_p1;
  end
  assign core_out  = c0_p2;
  assign core_out1 = c1_p2;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected responses are queued at every accepted block
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
    end else if (in_valid && in_ready) begin
      e.id   = in_id;
      e.data = salsa_ref(in_data, DR);
      exp_q.push_back(e);
      n_acc++;
    end
  end

  logic           r_hold = 1'b0;
  logic [511:0]   hold_data;
  logic [IDW-1:0] hold_id;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      r_hold = 1'b0;
    end else begin
      if (r_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_data);
        chk("hold_id", out_id, hold_id);
      end
      r_hold    = out_valid && !out_ready;
      hold_data = out_data;
      hold_id   = out_id;
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: got id %0h expected no output", out_id);
        end else begin
          e = exp_q.pop_front();
          chk("sb_id", out_id, e.id);
          chk("sb_data", out_data, e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_valid(input int lim, output int k);
    k = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (out_valid) begin k = i; break; end
    end
    if (k < 0) chk("timeout_out_valid", 0, 1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  logic [19:0]    ir, ov, iss;
  logic [IDW-1:0] oid [20];
  logic [511:0]   od  [20];
  logic [511:0]   rfc_in, rfc_out, blk;
  int             k, cnt, acc0, pop0;

  initial begin
    reset = 1'b1; in_valid = 0; in_data = '0; in_id = '0; out_ready = 1'b1;
    in_valid1 = 0; in_data1 = '0; in_id1 = '0; out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_core_issue", core_issue, 0);
    chk("rst_core_xx", core_xx, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    @(posedge clk); #1; reset = 1'b0;

    // zero block, issue pattern and latency
    ir = '0; ov = '0; iss = '0;
    in_valid = 1; in_data = '0; in_id = 4'd3;
    for (int j = 0; j < 12; j++) begin
      if (j == 1) in_valid = 0;
      @(negedge clk);
      iss[j] = core_issue; ov[j] = out_valid; oid[j] = out_id; od[j] = out_data;
      @(posedge clk); #1;
    end
    chk("zero_issue_pattern", iss[11:0], 12'b0000_0101_0101);
    chk("zero_valid_pattern", ov[11:0], 12'b0010_0000_0000);
    chk("zero_out_id", oid[9], 4'd3);
    chk("zero_out_data", od[9], 0);

    // RFC 7914 Salsa20/8 vector
    rfc_in  = 512'h7e879a214f3ec9867ca940e641718f26baee555b8c61c1b50df846116dcd3b1dee24f319df9b3d8514121e4b5ac5aa3276021d2909c74829edebc68db8b8c25e;
    rfc_out = 512'ha41f859c6608cc993b81cacb020cef05044b2181a2fd337dfd7b1c6396682f29b4393168e3c9e6bcfe6bc5b7a06d96bae424cc102c91745c24ad673dc7618f81;
    in_valid = 1; in_data = bytes_to_blk(rfc_in); in_id = 4'd7;
    @(negedge clk);
    chk("rfc_in_ready", in_ready, 1);
    @(posedge clk); #1; in_valid = 0;
    wait_valid(20, k);
    chk("rfc_latency", k, 8);
    chk("rfc_out_data", out_data, bytes_to_blk(rfc_out));
    chk("rfc_out_id", out_id, 4'd7);
    tick(2);

    // two back-to-back jobs, interleaved
    ir = '0; ov = '0;
    in_valid = 1; in_data = rnd512(); in_id = 4'd3;
    for (int j = 0; j < 13; j++) begin
      if (j == 1) begin in_data = rnd512(); in_id = 4'd5; end
      if (j == 2) in_valid = 0;
      @(negedge clk);
      ir[j] = in_ready; ov[j] = out_valid; oid[j] = out_id;
      @(posedge clk); #1;
    end
    chk("pair_ready_accept", ir[1:0], 2'b11);
    chk("pair_ready_busy", ir[9:2], 0);
    chk("pair_ready_free", ir[10], 1);
    chk("pair_valid_pattern", ov[12:0], 13'b0_0110_0000_0000);
    chk("pair_first_id", oid[9], 4'd3);
    chk("pair_second_id", oid[10], 4'd5);
    tick(2);

    // backpressure with both jobs done
    ir = '0; ov = '0;
    out_ready = 0;
    in_valid = 1; in_data = rnd512(); in_id = 4'd3;
    for (int j = 0; j < 19; j++) begin
      if (j == 1) begin in_data = rnd512(); in_id = 4'd5; end
      if (j == 2) in_valid = 0;
      if (j == 15) out_ready = 1;
      @(negedge clk);
      ir[j] = in_ready; ov[j] = out_valid; oid[j] = out_id; od[j] = out_data;
      @(posedge clk); #1;
    end
    chk("bp_valid_pattern", ov[18:0], 19'b001_1111_1110_0000_0000);
    chk("bp_ready_busy", ir[15:2], 0);
    chk("bp_ready_free", ir[16], 1);
    cnt = 0;
    for (int j = 9; j <= 15; j++) if (oid[j] !== 4'd3 || od[j] !== od[9]) cnt++;
    chk("bp_held_stable", cnt, 0);
    chk("bp_second_id", oid[16], 4'd5);
    tick(2);

    // reset in the middle of a running job
    in_valid = 1; in_data = rnd512(); in_id = 4'd9;
    tick(1); in_valid = 0;
    tick(3);
    reset = 1'b1; #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_core_issue", core_issue, 0);
    chk("midrst_core_xx", core_xx, 0);
    @(posedge clk); #1; reset = 1'b0;
    cnt = 0;
    repeat (15) begin @(negedge clk); if (out_valid) cnt++; end
    chk("midrst_no_output", cnt, 0);
    @(posedge clk); #1;
    in_valid = 1; in_data = rnd512(); in_id = 4'd10;
    @(negedge clk);
    chk("midrst_relaunch_ready", in_ready, 1);
    @(posedge clk); #1; in_valid = 0;
    wait_valid(20, k);
    chk("midrst_relaunch_latency", k, 8);
    chk("midrst_relaunch_id", out_id, 4'd10);
    tick(2);

    // single double round instance
    for (int t = 0; t < 2; t++) begin
      blk = (t == 0) ? '0 : rnd512();
      in_valid1 = 1; in_data1 = blk; in_id1 = 4'(t + 1);
      @(negedge clk);
      @(posedge clk); #1; in_valid1 = 0;
      k = -1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (out_valid1) begin k = i; break; end
      end
      chk("dr1_latency", k, 2);
      chk("dr1_out_data", out_data1, salsa_ref(blk, 1));
      chk("dr1_out_id", out_id1, 4'(t + 1));
      tick(2);
    end

    // random traffic with random backpressure
    acc0 = n_acc; pop0 = n_pop;
    for (int c = 0; c < 30000 && (n_acc - acc0) < 1000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rnd512();
      in_id     = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick(1);
    tick(2);
    chk("rand_jobs_accepted", n_acc - acc0, 1000);
    chk("rand_jobs_emitted", n_pop - pop0, 1000);
    chk("rand_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("rand_final_idle", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
